comparador_serial: RTL

Parametrised, clocked magnitude comparator that compares two WIDTH-bit words bit-serially, MSB first, under a start/busy/done handshake. It also registers per-bit relation vectors and drives three LEDs that blink the final relation. It sits between the board switch inputs and the LED bank, as the multi-bit, sequential generation of the bench's combinational comparator.

---
 rtl/comparador_serial.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/comparador_serial.sv
// rtl/comparador_serial.sv - bit-serial MSB-first magnitude comparator with blinking relation LEDs
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start                      compare request, sampled only while idle
//   a, b                       switch words (raw polarity)
//   busy, done, valid          handshake: busy in SHIFT/DONE, done pulse in DONE, result held
//   lt, eq, gt                 registered relation of captured words
//   lt_bits, eq_bits, gt_bits  per-bit relation vectors of captured words
//   led_lt, led_eq, led_gt     blinking indicator for the final relation

module comparador_serial #(
    parameter int WIDTH      = 8,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter int BLINK_HALF = 6_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [WIDTH-1:0] lt_bits,
    output logic [WIDTH-1:0] eq_bits,
    output logic [WIDTH-1:0] gt_bits,
    output logic             led_lt,
    output logic             led_eq,
    output logic             led_gt
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);
    localparam logic [IW-1:0] IDX_TOP  = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]   cnt_q;
    logic            phase_q;

    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic            bit_a;
    logic            bit_b;
    logic            bit_diff;

    assign cap_a    = ACTIVE_LOW ? ~a : a;
    assign cap_b    = ACTIVE_LOW ? ~b : b;
    assign bit_a    = a_q[idx_q];
    assign bit_b    = b_q[idx_q];
    assign bit_diff = bit_a ^ bit_b;

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (bit_diff || (idx_q == '0)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid   <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt_bits <= '0;
            eq_bits <= '0;
            gt_bits <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= cap_a;
                        b_q     <= cap_b;
                        lt_bits <= ~cap_a & cap_b;
                        eq_bits <= ~(cap_a ^ cap_b);
                        gt_bits <= cap_a & ~cap_b;
                        idx_q   <= IDX_TOP;
                        valid   <= 1'b0;
                        lt      <= 1'b0;
                        eq      <= 1'b0;
                        gt      <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    // First differing bit from the MSB decides the relation.
                    if (bit_diff) begin
                        gt <= bit_a;
                        lt <= bit_b;
                        eq <= 1'b0;
                    end else if (idx_q == '0) begin
                        eq <= 1'b1;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                S_DONE: valid <= 1'b1;
                default: ;
            endcase
        end
    end

    // Blink timebase: restarted in DONE so every result starts with a full ON half-period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (state_q == S_DONE) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (valid) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    logic on_lt;
    logic on_eq;
    logic on_gt;

    assign on_lt  = valid & lt & phase_q;
    assign on_eq  = valid & eq & phase_q;
    assign on_gt  = valid & gt & phase_q;
    assign led_lt = ACTIVE_LOW ? ~on_lt : on_lt;
    assign led_eq = ACTIVE_LOW ? ~on_eq : on_eq;
    assign led_gt = ACTIVE_LOW ? ~on_gt : on_gt;

endmodule
